// File: rtl/vdp_cpu_port.sv
// vdp_cpu_port: CPU-side I/O port of the 99-family VDP.
// Decodes data/control port strobes, runs the two-byte control latch, the
// VRAM address counter, the read-ahead buffer, the frame flag / IRQ and the
// write-only register file, and feeds a two-deep VRAM request queue.
module vdp_cpu_port #(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 14
) (
  input  logic                  phi,
  input  logic                  reset,
  input  logic                  cpu_mode,
  input  logic [7:0]            cpu_din,
  input  logic                  cpu_wr,
  input  logic                  cpu_rd,
  output logic [7:0]            cpu_dout,
  input  logic                  frame_tick,
  input  logic [6:0]            status_in,
  output logic [NUM_REGS*8-1:0] regs,
  output logic                  irq,
  output logic                  vram_req,
  output logic                  vram_we,
  output logic [ADDR_W-1:0]     vram_addr,
  output logic [7:0]            vram_wdata,
  input  logic                  vram_ack,
  input  logic [7:0]            vram_rdata,
  output logic                  overrun
);

  // Width of the address bits that live in reg14 (dummy 1 when unused).
  localparam int HI_W = (ADDR_W > 14) ? (ADDR_W - 14) : 1;

  // Strobe history and the one-cycle access pipeline stage.
  logic              wr_prev_q, rd_prev_q;
  logic              wr_take_s, rd_take_s;
  logic              acc_valid_q, acc_valid_d;
  logic              acc_write_q, acc_write_d;
  logic              acc_mode_q, acc_mode_d;
  logic [7:0]        acc_din_q, acc_din_d;

  // Decoded access kinds.
  logic              ctl_wr_s, data_wr_s, data_rd_s, stat_rd_s;
  logic              reg_wr_s, addr_set_s, read_setup_s;
  logic              new_req_s, carry_s;
  logic [13:0]       acc_lo_s;
  logic [ADDR_W-1:0] acc_addr_s;

  // Architectural state.
  logic [7:0]        tmp_q, tmp_d;
  logic              flag_q, flag_d;
  logic [13:0]       addr_lo_q, addr_lo_d;
  logic              f_q, f_d;
  logic [7:0]        rbuf_q, rbuf_d;
  logic [7:0]        dout_q, dout_d;
  logic              irq_q, irq_d;
  logic [7:0]        regs_q [NUM_REGS];
  logic [7:0]        regs_d [NUM_REGS];

  // Active VRAM request and the holding slot behind it.
  logic              vram_req_q, vram_req_d;
  logic              vram_we_q, vram_we_d;
  logic [ADDR_W-1:0] vram_addr_q, vram_addr_d;
  logic [7:0]        vram_wdata_q, vram_wdata_d;
  logic              slot_valid_q, slot_valid_d;
  logic              slot_we_q, slot_we_d;
  logic [ADDR_W-1:0] slot_addr_q, slot_addr_d;
  logic [7:0]        slot_wdata_q, slot_wdata_d;
  logic              promote_s;
  logic              overrun_q, overrun_d;

  // Rising-edge detect on the strobes; a simultaneous write wins over a read.
  always_comb begin
    wr_take_s   = cpu_wr & ~wr_prev_q;
    rd_take_s   = cpu_rd & ~rd_prev_q & ~wr_take_s;
    acc_valid_d = wr_take_s | rd_take_s;
    acc_write_d = wr_take_s;
    acc_mode_d  = cpu_mode;
    acc_din_d   = cpu_din;
  end

  // Classify the pipelined access and work out the address it uses.
  always_comb begin
    ctl_wr_s     = acc_valid_q & acc_write_q & acc_mode_q;
    data_wr_s    = acc_valid_q & acc_write_q & ~acc_mode_q;
    data_rd_s    = acc_valid_q & ~acc_write_q & ~acc_mode_q;
    stat_rd_s    = acc_valid_q & ~acc_write_q & acc_mode_q;
    reg_wr_s     = ctl_wr_s & flag_q & acc_din_q[7];
    addr_set_s   = ctl_wr_s & flag_q & ~acc_din_q[7];
    read_setup_s = addr_set_s & ~acc_din_q[6];
    new_req_s    = read_setup_s | data_wr_s | data_rd_s;
    if (addr_set_s) begin
      acc_lo_s = {acc_din_q[5:0], tmp_q};
    end else begin
      acc_lo_s = addr_lo_q;
    end
    carry_s = new_req_s & (acc_lo_s == 14'h3FFF);
    if (new_req_s) begin
      addr_lo_d = acc_lo_s + 14'd1;
    end else begin
      addr_lo_d = acc_lo_s;
    end
  end

  // Upper address bits come straight from reg14 when the address is wide.
  if (ADDR_W > 14) begin : g_hi_addr
    assign acc_addr_s = {regs_q[14][ADDR_W-15:0], acc_lo_s};
  end else begin : g_lo_addr
    assign acc_addr_s = acc_lo_s;
  end

  // Control latch, frame flag, read-data latch and IRQ next state.
  always_comb begin
    tmp_d  = tmp_q;
    flag_d = flag_q;
    if (ctl_wr_s) begin
      if (!flag_q) begin
        tmp_d  = acc_din_q;
        flag_d = 1'b1;
      end else begin
        flag_d = 1'b0;
      end
    end else if (data_wr_s || data_rd_s || stat_rd_s) begin
      flag_d = 1'b0;
    end else begin
      flag_d = flag_q;
    end

    // A tick in the same cycle as a status read keeps the flag set.
    if (stat_rd_s) begin
      f_d = frame_tick;
    end else if (frame_tick) begin
      f_d = 1'b1;
    end else begin
      f_d = f_q;
    end

    if (data_rd_s) begin
      dout_d = rbuf_q;
    end else if (stat_rd_s) begin
      dout_d = {f_q, status_in};
    end else begin
      dout_d = dout_q;
    end

    irq_d = f_q & regs_q[1][5];
  end

  // Register file: indexed writes plus the reg14 carry from the address counter.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (reg_wr_s && (acc_din_q[5:0] == 6'(i))) begin
        regs_d[i] = tmp_q;
      end else if ((ADDR_W > 14) && (i == 14) && carry_s) begin
        regs_d[i][HI_W-1:0] = regs_q[i][HI_W-1:0] + HI_W'(1);
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  // VRAM queue: retire on ack, promote the slot a cycle later, accept or drop new work.
  always_comb begin
    vram_req_d   = vram_req_q;
    vram_we_d    = vram_we_q;
    vram_addr_d  = vram_addr_q;
    vram_wdata_d = vram_wdata_q;
    slot_valid_d = slot_valid_q;
    slot_we_d    = slot_we_q;
    slot_addr_d  = slot_addr_q;
    slot_wdata_d = slot_wdata_q;
    overrun_d    = overrun_q;
    rbuf_d       = rbuf_q;

    if (vram_req_q && vram_ack) begin
      vram_req_d = 1'b0;
      if (!vram_we_q) begin
        rbuf_d = vram_rdata;
      end else begin
        rbuf_d = rbuf_q;
      end
    end else begin
      vram_req_d = vram_req_q;
    end

    // The request line has been low for a cycle here, so the slot may go out.
    promote_s = ~vram_req_q & slot_valid_q;
    if (promote_s) begin
      vram_req_d   = 1'b1;
      vram_we_d    = slot_we_q;
      vram_addr_d  = slot_addr_q;
      vram_wdata_d = slot_wdata_q;
      slot_valid_d = 1'b0;
    end else begin
      slot_valid_d = slot_valid_q;
    end

    if (new_req_s) begin
      if (!vram_req_q && !slot_valid_q) begin
        vram_req_d   = 1'b1;
        vram_we_d    = data_wr_s;
        vram_addr_d  = acc_addr_s;
        vram_wdata_d = acc_din_q;
      end else if (!slot_valid_q || promote_s) begin
        slot_valid_d = 1'b1;
        slot_we_d    = data_wr_s;
        slot_addr_d  = acc_addr_s;
        slot_wdata_d = acc_din_q;
      end else begin
        overrun_d = 1'b1;
      end
    end else begin
      overrun_d = overrun_q;
    end

    // Written data is what a following read should see.
    if (data_wr_s) begin
      rbuf_d = acc_din_q;
    end else begin
      rbuf_d = rbuf_d;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge phi) begin
    if (reset) begin
      wr_prev_q    <= 1'b0;
      rd_prev_q    <= 1'b0;
      acc_valid_q  <= 1'b0;
      acc_write_q  <= 1'b0;
      acc_mode_q   <= 1'b0;
      acc_din_q    <= 8'h00;
      tmp_q        <= 8'h00;
      flag_q       <= 1'b0;
      addr_lo_q    <= 14'h0000;
      f_q          <= 1'b0;
      rbuf_q       <= 8'h00;
      dout_q       <= 8'h00;
      irq_q        <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= 8'h00;
      end
      vram_req_q   <= 1'b0;
      vram_we_q    <= 1'b0;
      vram_addr_q  <= '0;
      vram_wdata_q <= 8'h00;
      slot_valid_q <= 1'b0;
      slot_we_q    <= 1'b0;
      slot_addr_q  <= '0;
      slot_wdata_q <= 8'h00;
      overrun_q    <= 1'b0;
    end else begin
      wr_prev_q    <= cpu_wr;
      rd_prev_q    <= cpu_rd;
      acc_valid_q  <= acc_valid_d;
      acc_write_q  <= acc_write_d;
      acc_mode_q   <= acc_mode_d;
      acc_din_q    <= acc_din_d;
      tmp_q        <= tmp_d;
      flag_q       <= flag_d;
      addr_lo_q    <= addr_lo_d;
      f_q          <= f_d;
      rbuf_q       <= rbuf_d;
      dout_q       <= dout_d;
      irq_q        <= irq_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      vram_req_q   <= vram_req_d;
      vram_we_q    <= vram_we_d;
      vram_addr_q  <= vram_addr_d;
      vram_wdata_q <= vram_wdata_d;
      slot_valid_q <= slot_valid_d;
      slot_we_q    <= slot_we_d;
      slot_addr_q  <= slot_addr_d;
      slot_wdata_q <= slot_wdata_d;
      overrun_q    <= overrun_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign regs[g*8 +: 8] = regs_q[g];
  end

  assign cpu_dout   = dout_q;
  assign irq        = irq_q;
  assign vram_req   = vram_req_q;
  assign vram_we    = vram_we_q;
  assign vram_addr  = vram_addr_q;
  assign vram_wdata = vram_wdata_q;
  assign overrun    = overrun_q;

endmodule
